// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and core status for the boot loader.
// The loader is the slave side; the byte source / memory / core harness is the master side.
interface imem_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_wen;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_wen, imem_waddr, imem_wdata, core_rst, done, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_wen, imem_waddr, imem_wdata, core_rst, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Framed byte-stream boot loader: length, little-endian words into IMEM, trailing 8-bit sum.
// Holds the core in reset until a complete, checksum-verified image has been written.
module imem_boot_loader #(
    parameter int unsigned IMEM_WORDS     = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   bus
);
    localparam int unsigned LEN_W = 16;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_n;
    logic [7:0]         len_lo_q, len_lo_n;
    logic [LEN_W-1:0]   n_words_q, n_words_n;
    logic [LEN_W-1:0]   w_q, w_n;
    logic [1:0]         byte_cnt_q, byte_cnt_n;
    logic [23:0]        word_q, word_n;
    logic [7:0]         sum_q, sum_n;
    logic [TMR_W-1:0]   tmr_q, tmr_n;

    logic               rx_ready_q, rx_ready_n;
    logic               wen_q, wen_n;
    logic [31:0]        waddr_q, waddr_n;
    logic [31:0]        wdata_q, wdata_n;
    logic               core_rst_q, core_rst_n;
    logic               done_q, done_n;
    logic               error_q, error_n;

    logic               xfer;
    logic               timeout;
    logic [LEN_W-1:0]   len_full;

    assign xfer     = bus.rx_valid && rx_ready_q;
    assign len_full = {bus.rx_data, len_lo_q};
    // Idle cycle that would bring the counter to the limit; a transfer on that cycle wins.
    assign timeout  = !xfer && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // Next-state and next-output logic
    always_comb begin
        state_n    = state_q;
        len_lo_n   = len_lo_q;
        n_words_n  = n_words_q;
        w_n        = w_q;
        byte_cnt_n = byte_cnt_q;
        word_n     = word_q;
        sum_n      = sum_q;
        tmr_n      = tmr_q;
        wen_n      = 1'b0;
        waddr_n    = waddr_q;
        wdata_n    = wdata_q;

        unique case (state_q)
            S_LEN0: begin
                if (xfer) begin
                    len_lo_n = bus.rx_data;
                    sum_n    = sum_q + bus.rx_data;
                    state_n  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    sum_n     = sum_q + bus.rx_data;
                    n_words_n = len_full;
                    if (len_full == '0 || len_full > LEN_W'(IMEM_WORDS)) begin
                        state_n = S_ERR;
                    end else begin
                        state_n = S_DATA;
                    end
                end else if (timeout) begin
                    state_n = S_ERR;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    sum_n      = sum_q + bus.rx_data;
                    byte_cnt_n = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: word_n[7:0]   = bus.rx_data;
                        2'd1: word_n[15:8]  = bus.rx_data;
                        2'd2: word_n[23:16] = bus.rx_data;
                        default: begin
                            wen_n   = 1'b1;
                            waddr_n = {14'd0, w_q, 2'b00};
                            wdata_n = {bus.rx_data, word_q};
                            w_n     = w_q + LEN_W'(1);
                            if (w_q == n_words_q - LEN_W'(1)) begin
                                state_n = S_CHK;
                            end
                        end
                    endcase
                end else if (timeout) begin
                    state_n = S_ERR;
                end
            end
            S_CHK: begin
                if (xfer) begin
                    state_n = (bus.rx_data == sum_q) ? S_DONE : S_ERR;
                end else if (timeout) begin
                    state_n = S_ERR;
                end
            end
            default: state_n = state_q;
        endcase

        // Inter-byte idle counter runs only once a frame has started
        if (xfer || state_q == S_LEN0) begin
            tmr_n = '0;
        end else if (state_q == S_LEN1 || state_q == S_DATA || state_q == S_CHK) begin
            tmr_n = tmr_q + TMR_W'(1);
        end

        rx_ready_n = (state_n != S_DONE) && (state_n != S_ERR);
        core_rst_n = (state_n != S_DONE);
        done_n     = (state_n == S_DONE);
        error_n    = (state_n == S_ERR);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LEN0;
            len_lo_q   <= '0;
            n_words_q  <= '0;
            w_q        <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            sum_q      <= '0;
            tmr_q      <= '0;
            rx_ready_q <= 1'b1;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_n;
            len_lo_q   <= len_lo_n;
            n_words_q  <= n_words_n;
            w_q        <= w_n;
            byte_cnt_q <= byte_cnt_n;
            word_q     <= word_n;
            sum_q      <= sum_n;
            tmr_q      <= tmr_n;
            rx_ready_q <= rx_ready_n;
            wen_q      <= wen_n;
            waddr_q    <= waddr_n;
            wdata_q    <= wdata_n;
            core_rst_q <= core_rst_n;
            done_q     <= done_n;
            error_q    <= error_n;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_wen   = wen_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
endmodule
